// File: rtl/genius_pkg.sv
// Shared types for the button-press path: colour encoding, collector states
// and small helpers that classify the active-low button vector.
// Optional feature macro: PRESS_TIMEOUT_EN (adds the EXPIRED state).
package genius_pkg;

   typedef logic [1:0] color_t;

   localparam color_t COLOR_0 = 2'd0;
   localparam color_t COLOR_1 = 2'd1;
   localparam color_t COLOR_2 = 2'd2;
   localparam color_t COLOR_3 = 2'd3;

`ifdef PRESS_TIMEOUT_EN
   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      EXPIRED  = 2'd2
   } press_state_t;
`else
   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1
   } press_state_t;
`endif

   // Number of buttons held low in the active-low vector {BTN3..BTN0}.
   function automatic logic [2:0] count_low(input logic [3:0] btn_n);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (!btn_n[i]) n = n + 3'd1;
      end
      return n;
   endfunction

   // Colour of the lowest-numbered low button; only meaningful when exactly one is low.
   function automatic color_t encode_btn(input logic [3:0] btn_n);
      color_t c;
      c = COLOR_0;
      if      (!btn_n[0]) c = COLOR_0;
      else if (!btn_n[1]) c = COLOR_1;
      else if (!btn_n[2]) c = COLOR_2;
      else if (!btn_n[3]) c = COLOR_3;
      return c;
   endfunction

endpackage

// File: rtl/press_fifo.sv
// First-word fall-through FIFO of colour codes.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   wr_en_i, wr_data_i push request and data (dropped if full without a pop)
//   rd_en_i            pop request (ignored while empty)
//   head_o, valid_o    registered head entry and non-empty flag
//   count_o            number of entries held
//   full_o, empty_o    status flags
module press_fifo
   import genius_pkg::*;
#(
   parameter int unsigned  DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_en_i,
   input  color_t           wr_data_i,
   input  logic             rd_en_i,
   output color_t           head_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   color_t             mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   color_t             head_q, head_d;
   logic               valid_q, valid_d;
   logic               do_rd, do_wr;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

   // Pointer, count and head update.
   always_comb begin
      do_rd    = rd_en_i && !empty_o;
      do_wr    = wr_en_i && (!full_o || do_rd);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      head_d   = head_q;

      if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (do_wr && !do_rd)      count_d = count_q + CNT_W'(1);
      else if (!do_wr && do_rd) count_d = count_q - CNT_W'(1);

      // Head holds its last value when the FIFO drains; with one entry left the
      // slot after the head is exactly where a same-cycle write lands.
      if (do_rd) begin
         if (count_q > CNT_W'(1)) head_d = mem_q[rd_ptr_d];
         else if (do_wr)          head_d = wr_data_i;
      end else if (do_wr && empty_o) begin
         head_d = wr_data_i;
      end

      valid_d = (count_d != '0);
   end

   // Control registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= COLOR_0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

   // Storage array; contents are only observable through the pointers.
   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign head_o  = head_q;
   assign valid_o = valid_q;
   assign count_o = count_q;

endmodule

// File: rtl/press_collector.sv
// Collects single button presses into a FWFT queue while the player input
// phase is armed; flags simultaneous presses and presses dropped when full.
// Optional feature macro: PRESS_TIMEOUT_EN (idle timer, EXPIRED state, TIMEOUT port).
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   BTN0..BTN3           one-cycle active-low press pulses
//   ARM                  input phase active
//   PRESS_READY          consumer pops the head entry
//   PRESS_VALID/COLOR    head entry present / its colour
//   FIFO_COUNT           entries held
//   MULTI_ERR, OVERFLOW  one-cycle error pulses
//   TIMEOUT              one-cycle idle-expiry pulse (PRESS_TIMEOUT_EN only)
module press_collector
   import genius_pkg::*;
#(
   parameter int unsigned  FIFO_DEPTH     = 4,
   parameter int unsigned  TIMEOUT_CYCLES = 50000000,
   localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             BTN0,
   input  logic             BTN1,
   input  logic             BTN2,
   input  logic             BTN3,
   input  logic             ARM,
   input  logic             PRESS_READY,
   output logic             PRESS_VALID,
   output color_t           PRESS_COLOR,
   output logic [CNT_W-1:0] FIFO_COUNT,
   output logic             MULTI_ERR,
`ifdef PRESS_TIMEOUT_EN
   output logic             OVERFLOW,
   output logic             TIMEOUT
`else
   output logic             OVERFLOW
`endif
);

   // Elaboration-time parameter legality.
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("press_collector: FIFO_DEPTH must be a power of two in 2..16");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("press_collector: TIMEOUT_CYCLES must be at least 2");
   end

   press_state_t state_q, state_d;
   logic         multi_q, multi_d;
   logic         ovf_q, ovf_d;

   logic [3:0]   btn_n;
   logic [2:0]   n_low;
   color_t       press_color;
   logic         is_armed, pop, fits, accept;

   logic         fifo_full, fifo_empty;

`ifdef PRESS_TIMEOUT_EN
   localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               timeout_q, timeout_d;
`endif

   assign btn_n       = {BTN3, BTN2, BTN1, BTN0};
   assign n_low       = count_low(btn_n);
   assign press_color = encode_btn(btn_n);
   assign is_armed    = (state_q == ARMED);
   assign pop         = !fifo_empty && PRESS_READY;
   // A full FIFO still takes a press when the head leaves in the same cycle.
   assign fits        = !fifo_full || pop;
   assign accept      = is_armed && (n_low == 3'd1) && fits;

   // Next-state and pulse logic.
   always_comb begin
      state_d = state_q;
      multi_d = 1'b0;
      ovf_d   = 1'b0;
`ifdef PRESS_TIMEOUT_EN
      timer_d   = timer_q;
      timeout_d = 1'b0;
`endif

      multi_d = is_armed && (n_low >= 3'd2);
      ovf_d   = is_armed && (n_low == 3'd1) && !fits;

      case (state_q)
         DISARMED: begin
`ifdef PRESS_TIMEOUT_EN
            timer_d = '0;
`endif
            if (ARM) state_d = ARMED;
         end
         ARMED: begin
            if (!ARM) begin
               state_d = DISARMED;
            end
`ifdef PRESS_TIMEOUT_EN
            // An accepted press in the terminal cycle restarts the window.
            else if (accept) begin
               timer_d = '0;
            end else if (timer_q == TIMER_LAST) begin
               state_d   = EXPIRED;
               timeout_d = 1'b1;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
`endif
         end
`ifdef PRESS_TIMEOUT_EN
         EXPIRED: begin
            if (!ARM) state_d = DISARMED;
         end
`endif
         default: state_d = DISARMED;
      endcase
   end

   // State and pulse registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= DISARMED;
         multi_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         multi_q <= multi_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef PRESS_TIMEOUT_EN
   // Idle timer registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         timer_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
      end
   end

   assign TIMEOUT = timeout_q;
`endif

   press_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (CLK),
      .rst_ni    (RST_N),
      .wr_en_i   (accept),
      .wr_data_i (press_color),
      .rd_en_i   (PRESS_READY),
      .head_o    (PRESS_COLOR),
      .valid_o   (PRESS_VALID),
      .count_o   (FIFO_COUNT),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign MULTI_ERR = multi_q;
   assign OVERFLOW  = ovf_q;

endmodule
